// File: rtl/seg7_scan_driver_if.sv
// Display-code bus for seg7_scan_driver: load-side controls in, scanned pin levels and status out.
// The master is the control logic producing codes; the slave is the scan driver.
interface seg7_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    logic                    load;
    logic [5*N_DIGITS-1:0]   glyphs;
    logic [N_DIGITS-1:0]     dp_in;
    logic [N_DIGITS-1:0]     blink_mask;
    logic [6:0]              seg;
    logic                    dp;
    logic [N_DIGITS-1:0]     an;
    logic                    frame_start;
    logic                    pending;

    modport master (
        output load, glyphs, dp_in, blink_mask,
        input  seg, dp, an, frame_start, pending
    );

    modport slave (
        input  load, glyphs, dp_in, blink_mask,
        output seg, dp, an, frame_start, pending
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with pending/shadow double buffering.
// Optional per-digit blinking is built in when SEG7_BLINK_EN is defined.
module seg7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 32
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_driver_if.slave bus
);

    localparam int RC_W = $clog2(REFRESH_DIV);
    localparam int DI_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int GW   = 5 * N_DIGITS;

    localparam logic [RC_W-1:0] RC_MAX    = RC_W'(REFRESH_DIV - 1);
    localparam logic [DI_W-1:0] DI_MAX    = DI_W'(N_DIGITS - 1);
    localparam logic [6:0]      SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_seg(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Letters A b C d E F H L; codes 8..15 are blank.
    function automatic logic [6:0] letter_seg(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'h08;
            4'h1:    s = 7'h03;
            4'h2:    s = 7'h46;
            4'h3:    s = 7'h21;
            4'h4:    s = 7'h06;
            4'h5:    s = 7'h0E;
            4'h6:    s = 7'h09;
            4'h7:    s = 7'h47;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] glyph_seg(input logic [4:0] glyph);
        return glyph[4] ? letter_seg(glyph[3:0]) : hex_seg(glyph[3:0]);
    endfunction

    logic [GW-1:0]       pend_glyph_q, pend_glyph_d;
    logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [N_DIGITS-1:0] pend_mask_q, pend_mask_d;
    logic                pending_q, pending_d;

    logic [GW-1:0]       shad_glyph_q, shad_glyph_d;
    logic [N_DIGITS-1:0] shad_dp_q, shad_dp_d;
    logic [N_DIGITS-1:0] shad_mask_q, shad_mask_d;

    logic [RC_W-1:0]     rc_q, rc_d;
    logic [DI_W-1:0]     di_q, di_d;

    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                frame_start_q, frame_start_d;

    logic                rc_wrap;
    logic                frame_end;
    logic                blink_on;
    logic [4:0]          cur_glyph;
    logic                cur_dp;
    logic                cur_blank;

    assign rc_wrap   = (rc_q == RC_MAX);
    assign frame_end = rc_wrap && (di_q == DI_MAX);

`ifdef SEG7_BLINK_EN
    localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(BLINK_DIV - 1);

    logic [BC_W-1:0] bc_q, bc_d;
    logic            phase_q, phase_d;

    // Frame counter advances only at frame boundaries so the phase flips between frames.
    always_comb begin
        bc_d    = bc_q;
        phase_d = phase_q;
        if (frame_end) begin
            if (bc_q == BC_MAX) begin
                bc_d    = '0;
                phase_d = ~phase_q;
            end else begin
                bc_d = bc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bc_q    <= '0;
            phase_q <= 1'b1;
        end else begin
            bc_q    <= bc_d;
            phase_q <= phase_d;
        end
    end

    assign blink_on = phase_q;
`else
    // No blink hardware: the phase is permanently on for any legal BLINK_DIV.
    assign blink_on = (BLINK_DIV > 0);
`endif

    always_comb begin
        rc_d = rc_wrap ? '0 : rc_q + 1'b1;
        di_d = di_q;
        if (rc_wrap) begin
            di_d = (di_q == DI_MAX) ? '0 : di_q + 1'b1;
        end
    end

    always_comb begin
        pend_glyph_d = pend_glyph_q;
        pend_dp_d    = pend_dp_q;
        pend_mask_d  = pend_mask_q;
        pending_d    = pending_q;
        if (bus.load) begin
            pend_glyph_d = bus.glyphs;
            pend_dp_d    = bus.dp_in;
            pend_mask_d  = bus.blink_mask;
            pending_d    = 1'b1;
        end
        // A commit always empties the pending level, including a same-cycle load.
        if (frame_end) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        shad_glyph_d = shad_glyph_q;
        shad_dp_d    = shad_dp_q;
        shad_mask_d  = shad_mask_q;
        if (frame_end) begin
            if (bus.load) begin
                shad_glyph_d = bus.glyphs;
                shad_dp_d    = bus.dp_in;
                shad_mask_d  = bus.blink_mask;
            end else if (pending_q) begin
                shad_glyph_d = pend_glyph_q;
                shad_dp_d    = pend_dp_q;
                shad_mask_d  = pend_mask_q;
            end
        end
    end

    // Outputs are a registered view of the shadow entry under the current digit index.
    always_comb begin
        cur_glyph     = shad_glyph_q[5*int'(di_q) +: 5];
        cur_dp        = shad_dp_q[di_q];
        cur_blank     = shad_mask_q[di_q] && !blink_on;
        seg_d         = cur_blank ? SEG_BLANK : glyph_seg(cur_glyph);
        dp_d          = cur_blank ? 1'b1 : ~cur_dp;
        an_d          = ~(N_DIGITS'(1) << di_q);
        frame_start_d = (rc_q == '0) && (di_q == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_glyph_q  <= {GW{1'b1}};
            pend_dp_q     <= '0;
            pend_mask_q   <= '0;
            pending_q     <= 1'b0;
            shad_glyph_q  <= {GW{1'b1}};
            shad_dp_q     <= '0;
            shad_mask_q   <= '0;
            rc_q          <= '0;
            di_q          <= '0;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            an_q          <= '1;
            frame_start_q <= 1'b0;
        end else begin
            pend_glyph_q  <= pend_glyph_d;
            pend_dp_q     <= pend_dp_d;
            pend_mask_q   <= pend_mask_d;
            pending_q     <= pending_d;
            shad_glyph_q  <= shad_glyph_d;
            shad_dp_q     <= shad_dp_d;
            shad_mask_q   <= shad_mask_d;
            rc_q          <= rc_d;
            di_q          <= di_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.frame_start = frame_start_q;
    assign bus.pending     = pending_q;

endmodule
